// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bundle for dmem_arbiter.
// slave modport: the arbiter (takes requests and mem_dout, drives ready/rsp/busy/mem_*).
// master modport: the requesters plus the memory instance around it.
interface dmem_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
);
    localparam int NBYTES = DWIDTH / 8;

    // Port 0: CPU load/store path
    logic              req0_valid;
    logic              req0_ready;
    logic [NBYTES-1:0] req0_wbe;
    logic [AWIDTH-1:0] req0_addr;
    logic [DWIDTH-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DWIDTH-1:0] rsp0_rdata;

    // Port 1: debug/loader path
    logic              req1_valid;
    logic              req1_ready;
    logic [NBYTES-1:0] req1_wbe;
    logic [AWIDTH-1:0] req1_addr;
    logic [DWIDTH-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DWIDTH-1:0] rsp1_rdata;

    // Status and memory side
    logic              busy;
    logic              mem_en;
    logic [NBYTES-1:0] mem_wbe;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [DWIDTH-1:0] mem_dout;

    modport slave (
        input  req0_valid, req0_wbe, req0_addr, req0_wdata,
        input  req1_valid, req1_wbe, req1_addr, req1_wdata,
        input  mem_dout,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output busy, mem_en, mem_wbe, mem_addr, mem_din
    );

    modport master (
        output req0_valid, req0_wbe, req0_addr, req0_wdata,
        output req1_valid, req1_wbe, req1_addr, req1_wdata,
        output mem_dout,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  busy, mem_en, mem_wbe, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a byte-write-enable data memory, with optional zero-fill after reset.
// Latency: request accepted in the cycle it is granted; read data registered, rspN_valid one cycle after acceptance.
// Backpressure: reqN_ready is low for the losing port of a tie and for both ports during reset or the clear sweep.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport) carries req0/1, rsp0/1, busy and mem_* signals.
module dmem_arbiter #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam logic [AWIDTH:0] LAST_ADDR = {1'b0, {AWIDTH{1'b1}}};
    localparam logic [AWIDTH:0] CNT_ONE   = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t            r_state;
    logic [AWIDTH:0]   r_clr_cnt;      // one extra bit so the last address is never confused with a wrap
    logic              r_last_grant;   // 1 after reset so port 0 wins the first tie
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DWIDTH-1:0] r_rsp0_rdata;
    logic [DWIDTH-1:0] r_rsp1_rdata;

    logic w_serve;
    logic w_gnt0;
    logic w_gnt1;

    // Grants are gated by rst_n so nothing is accepted while reset is asserted.
    assign w_serve = rst_n && (r_state == ST_SERVE);
    assign w_gnt0  = w_serve && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_gnt1  = w_serve && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.busy       = (r_state == ST_CLEAR);
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_rdata = r_rsp0_rdata;
    assign bus.rsp1_rdata = r_rsp1_rdata;

    always_comb begin
        bus.mem_en   = 1'b0;
        bus.mem_wbe  = '0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        if (rst_n && (r_state == ST_CLEAR)) begin
            bus.mem_en   = 1'b1;
            bus.mem_wbe  = '1;
            bus.mem_addr = r_clr_cnt[AWIDTH-1:0];
        end else if (w_gnt0) begin
            bus.mem_en   = 1'b1;
            bus.mem_wbe  = bus.req0_wbe;
            bus.mem_addr = bus.req0_addr;
            bus.mem_din  = bus.req0_wdata;
        end else if (w_gnt1) begin
            bus.mem_en   = 1'b1;
            bus.mem_wbe  = bus.req1_wbe;
            bus.mem_addr = bus.req1_addr;
            bus.mem_din  = bus.req1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_SERVE;
            r_clr_cnt    <= '0;
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            // Responses are single-cycle pulses; rdata holds until the next read on that port.
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + CNT_ONE;
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (w_gnt0) begin
                        r_last_grant <= 1'b0;
                        if (bus.req0_wbe == '0) begin
                            r_rsp0_valid <= 1'b1;
                            r_rsp0_rdata <= bus.mem_dout;
                        end
                    end else if (w_gnt1) begin
                        r_last_grant <= 1'b1;
                        if (bus.req1_wbe == '0) begin
                            r_rsp1_valid <= 1'b1;
                            r_rsp1_rdata <= bus.mem_dout;
                        end
                    end
                end
            endcase
        end
    end
endmodule
